// File: rtl/pixel_stream_sink_if.sv
// Pixel stream handshake between the coordinate generator (master) and the frame-buffer sink (slave).
interface pixel_stream_sink_if #(
    parameter int RBG_SIZE = 24
);
    logic                valid;
    logic [RBG_SIZE-1:0] colour;
    logic                first;
    logic                last_x;
    logic                last_y;
    logic                ready;

    modport master (output valid, output colour, output first, output last_x, output last_y, input ready);
    modport slave  (input valid, input colour, input first, input last_x, input last_y, output ready);
endinterface

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: checks frame framing, rebuilds x/y and writes pixels to a linear frame buffer at y*W+x.
// Optional feature macro PIXEL_SINK_ERR_CNT_EN adds a saturating sync-error counter output o_err_count.
module pixel_stream_sink #(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int ADDR_WIDTH    = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_stream_sink_if.slave    s_pix,
    input  logic                  i_mem_wait,
    output logic                  o_mem_wr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [RBG_SIZE-1:0]   o_mem_data,
    output logic [DATA_WIDTH-1:0] o_cur_x,
    output logic [DATA_WIDTH-1:0] o_cur_y,
`ifdef PIXEL_SINK_ERR_CNT_EN
    output logic [15:0]           o_err_count,
`endif
    output logic                  o_frame_done,
    output logic                  o_sync_err
);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, RESYNC} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [RBG_SIZE-1:0]   data;
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic                  eof;
    } entry_t;

    localparam logic [DATA_WIDTH-1:0] LAST_X = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] LAST_Y = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready;
    entry_t                r_buf [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    entry_t                r_out;
    logic                  r_out_vld;
    logic                  r_frame_done;
    logic                  r_sync_err;
`ifdef PIXEL_SINK_ERR_CNT_EN
    logic [15:0]           r_err_count;
`endif

    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_pix_x;
    logic [DATA_WIDTH-1:0] w_pix_y;
    logic [ADDR_WIDTH-1:0] w_pix_addr;
    logic                  w_exp_last_x;
    logic                  w_exp_last_y;
    logic [DATA_WIDTH-1:0] w_next_x;
    logic [DATA_WIDTH-1:0] w_next_y;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_push;
    logic                  w_err;
    logic                  w_eof;
    logic                  w_advance;
    state_t                w_next_state;
    entry_t                w_new;
    logic                  w_out_free;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_fifo_push;
    logic [1:0]            w_count_nxt;

    // A first flag always re-anchors the pixel at (0,0), whatever the tracked position was.
    always_comb begin
        w_xfer       = s_pix.valid && r_ready;
        w_pix_x      = s_pix.first ? '0 : r_x;
        w_pix_y      = s_pix.first ? '0 : r_y;
        w_pix_addr   = s_pix.first ? '0 : r_addr;
        w_exp_last_x = (w_pix_x == LAST_X);
        w_exp_last_y = w_exp_last_x && (w_pix_y == LAST_Y);
        w_next_x     = w_exp_last_x ? '0 : w_pix_x + DATA_WIDTH'(1);
        w_next_y     = w_exp_last_x ? w_pix_y + DATA_WIDTH'(1) : w_pix_y;
        w_next_addr  = w_pix_addr + ADDR_WIDTH'(1);
        w_push       = 1'b0;
        w_err        = 1'b0;
        w_eof        = 1'b0;
        w_advance    = 1'b0;
        w_next_state = r_state;
        if (w_xfer) begin
            case (r_state)
                ACTIVE: begin
                    if (s_pix.first) begin
                        w_err     = 1'b1;
                        w_push    = 1'b1;
                        w_advance = 1'b1;
                    end else if ((s_pix.last_x != w_exp_last_x) || (s_pix.last_y != w_exp_last_y)) begin
                        w_err        = 1'b1;
                        w_next_state = RESYNC;
                    end else begin
                        w_push = 1'b1;
                        if (w_exp_last_y) begin
                            w_eof        = 1'b1;
                            w_next_state = WAIT_SOF;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
                default: begin
                    if (s_pix.first) begin
                        w_push = 1'b1;
                        if (s_pix.last_y && w_exp_last_y) begin
                            w_eof        = 1'b1;
                            w_next_state = WAIT_SOF;
                        end else begin
                            w_advance    = 1'b1;
                            w_next_state = ACTIVE;
                        end
                    end
                end
            endcase
        end
        w_new.addr = w_pix_addr;
        w_new.data = s_pix.colour;
        w_new.x    = w_pix_x;
        w_new.y    = w_pix_y;
        w_new.eof  = w_eof;
    end

    // Output register drains the skid buffer first; a new pixel bypasses straight to it when the buffer is empty.
    always_comb begin
        w_out_free  = !r_out_vld || !i_mem_wait;
        w_pop       = w_out_free && (r_count != 2'd0);
        w_bypass    = w_out_free && (r_count == 2'd0) && w_push;
        w_fifo_push = w_push && !w_bypass;
        w_count_nxt = r_count + {1'b0, w_fifo_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_SOF;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_ready      <= 1'b0;
            for (int i = 0; i < 2; i++) r_buf[i] <= '0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_out        <= '0;
            r_out_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef PIXEL_SINK_ERR_CNT_EN
            r_err_count  <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_advance) begin
                r_x    <= w_next_x;
                r_y    <= w_next_y;
                r_addr <= w_next_addr;
            end
            if (w_fifo_push) begin
                r_buf[r_wr_ptr] <= w_new;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
            if (w_out_free) begin
                if (r_count != 2'd0) begin
                    r_out     <= r_buf[r_rd_ptr];
                    r_out_vld <= 1'b1;
                end else if (w_push) begin
                    r_out     <= w_new;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
            r_frame_done <= r_out_vld && !i_mem_wait && r_out.eof;
            r_sync_err   <= w_err;
`ifdef PIXEL_SINK_ERR_CNT_EN
            if (w_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
`endif
        end
    end

    assign s_pix.ready  = r_ready;
    assign o_mem_wr     = r_out_vld;
    assign o_mem_addr   = r_out.addr;
    assign o_mem_data   = r_out.data;
    assign o_cur_x      = r_out.x;
    assign o_cur_y      = r_out.y;
    assign o_frame_done = r_frame_done;
    assign o_sync_err   = r_sync_err;
`ifdef PIXEL_SINK_ERR_CNT_EN
    assign o_err_count  = r_err_count;
`endif

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink on a 4x2 screen; a negedge monitor logs completed memory writes.
module tb_pixel_stream_sink;

    logic        clk;
    logic        rstN;
    logic        memWait;
    logic        memWr;
    logic [7:0]  memAddr;
    logic [23:0] memData;
    logic [31:0] curX;
    logic [31:0] curY;
    logic        frameDone;
    logic        syncErr;
`ifdef PIXEL_SINK_ERR_CNT_EN
    logic [15:0] errCountOut;
`endif

    int testCount = 0;
    int failCount = 0;
    int doneCount = 0;
    int errCount  = 0;
    bit sawLow;
    bit stallBad;

    logic [7:0]  wrAddr [$];
    logic [23:0] wrData [$];
    logic [31:0] wrX [$];
    logic [31:0] wrY [$];

    pixel_stream_sink_if #(.RBG_SIZE(24)) pix ();

    pixel_stream_sink #(
        .DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .s_pix(pix),
        .i_mem_wait(memWait),
        .o_mem_wr(memWr),
        .o_mem_addr(memAddr),
        .o_mem_data(memData),
        .o_cur_x(curX),
        .o_cur_y(curY),
`ifdef PIXEL_SINK_ERR_CNT_EN
        .o_err_count(errCountOut),
`endif
        .o_frame_done(frameDone),
        .o_sync_err(syncErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWr && !memWait) begin
            wrAddr.push_back(memAddr);
            wrData.push_back(memData);
            wrX.push_back(curX);
            wrY.push_back(curY);
        end
        if (frameDone) doneCount++;
        if (syncErr) errCount++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        pix.valid = 1'b0;
        memWait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Holds one pixel on the bus until accepted; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [23:0] col, input logic f, input logic lx, input logic ly);
        int guard;
        guard = 0;
        pix.valid  = 1'b1;
        pix.colour = col;
        pix.first  = f;
        pix.last_x = lx;
        pix.last_y = ly;
        forever begin
            @(negedge clk);
            if (pix.ready) break;
            guard++;
            if (guard > 100) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL accept_timeout ready=%0b required 1", pix.ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix.valid = 1'b0;
    endtask

    task automatic sendIdx(input int i, input logic [23:0] base);
        applyStimulus(base + 24'(i), (i == 0), ((i % 4) == 3), (i == 7));
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        memWait = 1'b0;
        pix.valid = 1'b0;
        pix.colour = '0;
        pix.first = 1'b0;
        pix.last_x = 1'b0;
        pix.last_y = 1'b0;
        @(negedge clk);
        @(negedge clk);
        testCount++;
        if (pix.ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got=%0b required 0", pix.ready); end
        testCount++;
        if (memWr !== 1'b0 || memAddr !== 8'd0 || memData !== 24'd0) begin
            failCount++;
            $display("[TB] FAIL reset_mem wr=%0b addr=%0d data=%h required 0/0/0", memWr, memAddr, memData);
        end
        testCount++;
        if (curX !== 32'd0 || curY !== 32'd0 || frameDone !== 1'b0 || syncErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_misc x=%0d y=%0d done=%0b err=%0b required all 0", curX, curY, frameDone, syncErr);
        end
`ifdef PIXEL_SINK_ERR_CNT_EN
        testCount++;
        if (errCountOut !== 16'd0) begin failCount++; $display("[TB] FAIL reset_err_count got=%0d required 0", errCountOut); end
`endif
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        testCount++;
        if (pix.ready !== 1'b1) begin failCount++; $display("[TB] FAIL ready_after_reset got=%0b required 1", pix.ready); end
    endtask

    task automatic test_clean_frame();
        int base, d0, e0;
        idle(4);
        base = wrAddr.size(); d0 = doneCount; e0 = errCount;
        applyStimulus(24'h100000, 1'b1, 1'b0, 1'b0);
        testCount++;
        if (memWr !== 1'b1 || memAddr !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL clean_latency wr=%0b addr=%0d required wr=1 addr=0", memWr, memAddr);
        end
        for (int i = 1; i < 8; i++) sendIdx(i, 24'h100000);
        idle(6);
        testCount++;
        if (wrAddr.size() - base != 8) begin failCount++; $display("[TB] FAIL clean_count got=%0d required 8", wrAddr.size() - base); end
        for (int i = 0; i < 8 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== 24'h100000 + 24'(i) ||
                wrX[base+i] !== 32'(i % 4) || wrY[base+i] !== 32'(i / 4)) begin
                failCount++;
                $display("[TB] FAIL clean_write%0d addr=%0d data=%h x=%0d y=%0d required addr=%0d x=%0d y=%0d",
                         i, wrAddr[base+i], wrData[base+i], wrX[base+i], wrY[base+i], i, i % 4, i / 4);
            end
        end
        testCount++;
        if (doneCount - d0 != 1 || errCount - e0 != 0) begin
            failCount++;
            $display("[TB] FAIL clean_pulses done=%0d err=%0d required 1/0", doneCount - d0, errCount - e0);
        end
    endtask

    task automatic test_mem_wait();
        int base, d0;
        idle(4);
        base = wrAddr.size(); d0 = doneCount;
        for (int i = 0; i < 3; i++) sendIdx(i, 24'h200000);
        memWait = 1'b1;
        sawLow = 1'b0;
        stallBad = 1'b0;
        fork
            for (int i = 3; i < 8; i++) sendIdx(i, 24'h200000);
            begin
                repeat (3) begin
                    @(negedge clk);
                    if (!pix.ready) sawLow = 1'b1;
                    if (memWr !== 1'b1 || memAddr !== 8'd2) stallBad = 1'b1;
                    @(posedge clk);
                end
                #1;
                memWait = 1'b0;
            end
        join
        idle(8);
        testCount++;
        if (sawLow !== 1'b1) begin failCount++; $display("[TB] FAIL wait_ready_drop got=%0b required 1", sawLow); end
        testCount++;
        if (stallBad !== 1'b0) begin failCount++; $display("[TB] FAIL wait_hold_port got=%0b required 0", stallBad); end
        testCount++;
        if (wrAddr.size() - base != 8) begin failCount++; $display("[TB] FAIL wait_count got=%0d required 8", wrAddr.size() - base); end
        for (int i = 0; i < 8 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== 24'h200000 + 24'(i)) begin
                failCount++;
                $display("[TB] FAIL wait_write%0d addr=%0d data=%h required addr=%0d data=%h",
                         i, wrAddr[base+i], wrData[base+i], i, 24'h200000 + 24'(i));
            end
        end
        testCount++;
        if (doneCount - d0 != 1) begin failCount++; $display("[TB] FAIL wait_done got=%0d required 1", doneCount - d0); end
    endtask

    task automatic test_no_sof();
        int base, d0, e0;
        applyReset();
        base = wrAddr.size(); d0 = doneCount; e0 = errCount;
        applyStimulus(24'h300001, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'h300002, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'h300003, 1'b0, 1'b1, 1'b0);
        idle(4);
        testCount++;
        if (wrAddr.size() != base || errCount != e0) begin
            failCount++;
            $display("[TB] FAIL nosof_dropped writes=%0d errs=%0d required 0/0", wrAddr.size() - base, errCount - e0);
        end
        for (int i = 0; i < 8; i++) sendIdx(i, 24'h300000);
        idle(6);
        testCount++;
        if (wrAddr.size() - base != 8) begin failCount++; $display("[TB] FAIL nosof_count got=%0d required 8", wrAddr.size() - base); end
        for (int i = 0; i < 8 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== 8'(i)) begin
                failCount++;
                $display("[TB] FAIL nosof_addr%0d got=%0d required %0d", i, wrAddr[base+i], i);
            end
        end
        testCount++;
        if (doneCount - d0 != 1) begin failCount++; $display("[TB] FAIL nosof_done got=%0d required 1", doneCount - d0); end
    endtask

    task automatic test_last_x_err();
        int base, d0, e0;
        logic [7:0]  expA [10];
        logic [23:0] expD [10];
        idle(4);
        base = wrAddr.size(); d0 = doneCount; e0 = errCount;
        sendIdx(0, 24'h400000);
        sendIdx(1, 24'h400000);
        applyStimulus(24'h400002, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h400003, 1'b0, 1'b1, 1'b0);
        idle(3);
        testCount++;
        if (errCount - e0 != 1) begin failCount++; $display("[TB] FAIL lastx_sync_err got=%0d required 1", errCount - e0); end
        for (int i = 0; i < 8; i++) sendIdx(i, 24'h410000);
        idle(6);
        expA[0] = 8'd0; expD[0] = 24'h400000;
        expA[1] = 8'd1; expD[1] = 24'h400001;
        for (int i = 0; i < 8; i++) begin expA[i+2] = 8'(i); expD[i+2] = 24'h410000 + 24'(i); end
        testCount++;
        if (wrAddr.size() - base != 10) begin failCount++; $display("[TB] FAIL lastx_count got=%0d required 10", wrAddr.size() - base); end
        for (int i = 0; i < 10 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== expA[i] || wrData[base+i] !== expD[i]) begin
                failCount++;
                $display("[TB] FAIL lastx_write%0d addr=%0d data=%h required addr=%0d data=%h",
                         i, wrAddr[base+i], wrData[base+i], expA[i], expD[i]);
            end
        end
        testCount++;
        if (doneCount - d0 != 1 || errCount - e0 != 1) begin
            failCount++;
            $display("[TB] FAIL lastx_pulses done=%0d err=%0d required 1/1", doneCount - d0, errCount - e0);
        end
    endtask

    task automatic test_first_mid();
        int base, d0, e0;
        logic [7:0]  expA [13];
        logic [23:0] expD [13];
        idle(4);
        base = wrAddr.size(); d0 = doneCount; e0 = errCount;
        for (int i = 0; i < 5; i++) sendIdx(i, 24'h500000);
        applyStimulus(24'h5000AA, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) sendIdx(i, 24'h510000);
        idle(6);
        for (int i = 0; i < 5; i++) begin expA[i] = 8'(i); expD[i] = 24'h500000 + 24'(i); end
        expA[5] = 8'd0; expD[5] = 24'h5000AA;
        for (int i = 1; i < 8; i++) begin expA[i+5] = 8'(i); expD[i+5] = 24'h510000 + 24'(i); end
        testCount++;
        if (wrAddr.size() - base != 13) begin failCount++; $display("[TB] FAIL firstmid_count got=%0d required 13", wrAddr.size() - base); end
        for (int i = 0; i < 13 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== expA[i] || wrData[base+i] !== expD[i]) begin
                failCount++;
                $display("[TB] FAIL firstmid_write%0d addr=%0d data=%h required addr=%0d data=%h",
                         i, wrAddr[base+i], wrData[base+i], expA[i], expD[i]);
            end
        end
        testCount++;
        if (doneCount - d0 != 1 || errCount - e0 != 1) begin
            failCount++;
            $display("[TB] FAIL firstmid_pulses done=%0d err=%0d required 1/1", doneCount - d0, errCount - e0);
        end
    endtask

    task automatic test_reset_mid();
        int base, d0, e0;
        idle(4);
        for (int i = 0; i < 4; i++) sendIdx(i, 24'h600000);
        rstN = 1'b0;
        #1;
        testCount++;
        if (memWr !== 1'b0 || memAddr !== 8'd0 || memData !== 24'd0 || curX !== 32'd0 || curY !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL resetmid_outputs wr=%0b addr=%0d data=%h x=%0d y=%0d required all 0",
                     memWr, memAddr, memData, curX, curY);
        end
        testCount++;
        if (pix.ready !== 1'b0) begin failCount++; $display("[TB] FAIL resetmid_ready got=%0b required 0", pix.ready); end
        idle(2);
        rstN = 1'b1;
        base = wrAddr.size(); d0 = doneCount; e0 = errCount;
        for (int i = 0; i < 8; i++) sendIdx(i, 24'h610000);
        idle(6);
        testCount++;
        if (wrAddr.size() - base != 8) begin failCount++; $display("[TB] FAIL resetmid_count got=%0d required 8", wrAddr.size() - base); end
        for (int i = 0; i < 8 && base + i < wrAddr.size(); i++) begin
            testCount++;
            if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== 24'h610000 + 24'(i)) begin
                failCount++;
                $display("[TB] FAIL resetmid_write%0d addr=%0d data=%h required addr=%0d", i, wrAddr[base+i], wrData[base+i], i);
            end
        end
        testCount++;
        if (doneCount - d0 != 1 || errCount - e0 != 0) begin
            failCount++;
            $display("[TB] FAIL resetmid_pulses done=%0d err=%0d required 1/0", doneCount - d0, errCount - e0);
        end
`ifdef PIXEL_SINK_ERR_CNT_EN
        applyStimulus(24'h620000, 1'b1, 1'b0, 1'b0);
        applyStimulus(24'h620001, 1'b0, 1'b1, 1'b0);
        applyStimulus(24'h620002, 1'b1, 1'b0, 1'b0);
        applyStimulus(24'h620003, 1'b0, 1'b0, 1'b1);
        idle(3);
        testCount++;
        if (errCountOut !== 16'd2) begin failCount++; $display("[TB] FAIL err_count_two got=%0d required 2", errCountOut); end
        applyReset();
        testCount++;
        if (errCountOut !== 16'd0) begin failCount++; $display("[TB] FAIL err_count_cleared got=%0d required 0", errCountOut); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_mem_wait();
        test_no_sof();
        test_last_x_err();
        test_first_mid();
        test_reset_mid();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
